// File: rtl/ballot_terminal_sequencer.sv
// ballot_terminal_sequencer
//   Voter-side booth front end. Turns card-reader and keypad events into the
//   voting controller's authenticate/submit handshakes: latches the voter ID,
//   pulses authenticate_voter, samples the verdict AUTH_LAT cycles later,
//   collects a candidate, pulses submit_vote and waits (with timeout) for the
//   accept/reject response.
//
//   Build option: define BALLOT_CONFIRM_EN for two-step entry
//   (SELECT -> CONFIRM -> SUBMIT). Undefined: a valid key goes straight to
//   SUBMIT and key_confirm is ignored.
//
//   Ports
//     clk, reset_n                 clock, async active-low reset
//     card_valid, card_id[7:0]     card reader event
//     key_press, key_code[3:0]     candidate key event
//     key_confirm, key_cancel      confirm / cancel keys
//     system_ready, system_status  controller status (8'h01 = authenticated)
//     vote_accepted, vote_rejected controller response pulses
//     error_code[7:0]              controller error code
//     voter_id_out, candidate_out  to controller
//     authenticate_voter           one-cycle auth request
//     submit_vote                  one-cycle submit request
//     busy, term_state[2:0]        session status / encoded state
//     ballot_done, fail            one-cycle session outcome pulses
//     fail_code[7:0]               reason for last fail, held
module ballot_terminal_sequencer #(
  parameter int unsigned AUTH_LAT     = 2,
  parameter int unsigned RESP_TIMEOUT = 8,
  parameter int unsigned NUM_CAND     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       card_valid,
  input  logic [7:0] card_id,
  input  logic       key_press,
  input  logic [3:0] key_code,
  input  logic       key_confirm,
  input  logic       key_cancel,
  input  logic       system_ready,
  input  logic [7:0] system_status,
  input  logic       vote_accepted,
  input  logic       vote_rejected,
  input  logic [7:0] error_code,
  output logic [7:0] voter_id_out,
  output logic [3:0] candidate_out,
  output logic       authenticate_voter,
  output logic       submit_vote,
  output logic       busy,
  output logic [2:0] term_state,
  output logic       ballot_done,
  output logic       fail,
  output logic [7:0] fail_code
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_AUTH    = 3'd1,
    S_SELECT  = 3'd2,
`ifdef BALLOT_CONFIRM_EN
    S_CONFIRM = 3'd3,
`endif
    S_SUBMIT  = 3'd4
  } state_e;

  localparam logic [7:0] CODE_CANCEL  = 8'h10;
  localparam logic [7:0] CODE_NOREADY = 8'hFD;
  localparam logic [7:0] CODE_TIMEOUT = 8'hFE;
  localparam logic [7:0] CODE_NOAUTH  = 8'hFF;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] voter_id_q, voter_id_d;
  logic [3:0] cand_q, cand_d;
  logic       auth_q, auth_d;
  logic       submit_q, submit_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       fail_q, fail_d;
  logic [7:0] fail_code_q, fail_code_d;
  logic       key_ok;

`ifndef BALLOT_CONFIRM_EN
  logic unused_confirm;
  assign unused_confirm = key_confirm;
`endif

  assign key_ok = key_press && (32'(key_code) < NUM_CAND);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    voter_id_d  = voter_id_q;
    cand_d      = cand_q;
    auth_d      = 1'b0;
    submit_d    = 1'b0;
    done_d      = 1'b0;
    fail_d      = 1'b0;
    fail_code_d = fail_code_q;

    // Loss of system_ready aborts any session ahead of every other event.
    if (state_q != S_IDLE && !system_ready) begin
      state_d     = S_IDLE;
      fail_d      = 1'b1;
      fail_code_d = CODE_NOREADY;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A card arriving on the outcome-pulse cycle is dropped.
          if (card_valid && system_ready && !done_q && !fail_q) begin
            voter_id_d = card_id;
            auth_d     = 1'b1;
            cnt_d      = '0;
            state_d    = S_AUTH;
          end
        end
        S_AUTH: begin
          if (cnt_q == 8'(AUTH_LAT)) begin
            if (system_status == 8'h01 && error_code == 8'h00) begin
              state_d = S_SELECT;
            end else begin
              state_d     = S_IDLE;
              fail_d      = 1'b1;
              fail_code_d = (error_code == 8'h00) ? CODE_NOAUTH : error_code;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_SELECT: begin
          if (key_cancel) begin
            state_d     = S_IDLE;
            fail_d      = 1'b1;
            fail_code_d = CODE_CANCEL;
          end else if (key_ok) begin
            cand_d  = key_code;
`ifdef BALLOT_CONFIRM_EN
            state_d = S_CONFIRM;
`else
            state_d  = S_SUBMIT;
            submit_d = 1'b1;
            cnt_d    = '0;
`endif
          end
        end
`ifdef BALLOT_CONFIRM_EN
        S_CONFIRM: begin
          if (key_cancel) begin
            state_d     = S_IDLE;
            fail_d      = 1'b1;
            fail_code_d = CODE_CANCEL;
          end else if (key_confirm) begin
            state_d  = S_SUBMIT;
            submit_d = 1'b1;
            cnt_d    = '0;
          end else if (key_ok) begin
            cand_d = key_code;
          end
        end
`endif
        S_SUBMIT: begin
          // A response on the timeout cycle still counts as a response.
          if (vote_accepted) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (vote_rejected) begin
            state_d     = S_IDLE;
            fail_d      = 1'b1;
            fail_code_d = error_code;
          end else if (cnt_q == 8'(RESP_TIMEOUT)) begin
            state_d     = S_IDLE;
            fail_d      = 1'b1;
            fail_code_d = CODE_TIMEOUT;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      voter_id_q  <= '0;
      cand_q      <= '0;
      auth_q      <= 1'b0;
      submit_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_code_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      voter_id_q  <= voter_id_d;
      cand_q      <= cand_d;
      auth_q      <= auth_d;
      submit_q    <= submit_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_code_q <= fail_code_d;
    end
  end

  assign voter_id_out       = voter_id_q;
  assign candidate_out      = cand_q;
  assign authenticate_voter = auth_q;
  assign submit_vote        = submit_q;
  assign busy               = busy_q;
  assign term_state         = state_q;
  assign ballot_done        = done_q;
  assign fail               = fail_q;
  assign fail_code          = fail_code_q;

endmodule

// File: tb/tb_ballot_terminal_sequencer.sv
module tb_ballot_terminal_sequencer;

  localparam int unsigned AUTH_LAT     = 2;
  localparam int unsigned RESP_TIMEOUT = 8;
  localparam int unsigned NUM_CAND     = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       card_valid, key_press, key_confirm, key_cancel;
  logic [7:0] card_id;
  logic [3:0] key_code;
  logic       system_ready, vote_accepted, vote_rejected;
  logic [7:0] system_status, error_code;
  logic [7:0] voter_id_out, fail_code;
  logic [3:0] candidate_out;
  logic       authenticate_voter, submit_vote, busy, ballot_done, fail;
  logic [2:0] term_state;

  int checks   = 0;
  int failures = 0;

  ballot_terminal_sequencer #(
    .AUTH_LAT(AUTH_LAT),
    .RESP_TIMEOUT(RESP_TIMEOUT),
    .NUM_CAND(NUM_CAND)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .card_valid(card_valid), .card_id(card_id),
    .key_press(key_press), .key_code(key_code),
    .key_confirm(key_confirm), .key_cancel(key_cancel),
    .system_ready(system_ready), .system_status(system_status),
    .vote_accepted(vote_accepted), .vote_rejected(vote_rejected),
    .error_code(error_code),
    .voter_id_out(voter_id_out), .candidate_out(candidate_out),
    .authenticate_voter(authenticate_voter), .submit_vote(submit_vote),
    .busy(busy), .term_state(term_state),
    .ballot_done(ballot_done), .fail(fail), .fail_code(fail_code)
  );

  always #5 clk = ~clk;

  // resp: 0 accept, 1 reject, 2 accept+reject together
  typedef struct {
    logic [7:0] card;
    logic [7:0] status;
    logic [7:0] err;
    logic [3:0] key;
    logic [1:0] resp;
    logic [7:0] resp_err;
    logic       auth_ok;
    logic       exp_done;
    logic [7:0] exp_code;
  } vec_t;

  vec_t vecs[7];
  logic [7:0] last_code;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_session(input logic [7:0] id);
    card_valid = 1'b1;
    card_id    = id;
    step();
    card_valid = 1'b0;
    chk("auth_pulse", authenticate_voter, 1);
    chk("voter_id", voter_id_out, id);
    chk("state_auth", term_state, 1);
    chk("busy_auth", busy, 1);
  endtask

  // Verdict is presented only during the sample cycle N+1+AUTH_LAT.
  task automatic auth_phase(input logic [7:0] st, input logic [7:0] er);
    for (int i = 0; i < AUTH_LAT; i++) begin
      step();
      if (i == 0) chk("auth_pulse_once", authenticate_voter, 0);
    end
    system_status = st;
    error_code    = er;
    step();
    system_status = 8'h00;
    error_code    = 8'h00;
  endtask

  task automatic enter_choice(input logic [3:0] k);
    key_press = 1'b1;
    key_code  = k;
    step();
    key_press = 1'b0;
`ifdef BALLOT_CONFIRM_EN
    chk("state_confirm", term_state, 3);
    chk("submit_early", submit_vote, 0);
    key_confirm = 1'b1;
    step();
    key_confirm = 1'b0;
`endif
    chk("submit_pulse", submit_vote, 1);
    chk("state_submit", term_state, 4);
    chk("cand_at_submit", candidate_out, k);
  endtask

  initial begin
    vecs[0] = '{8'h05, 8'h01, 8'h00, 4'd2, 2'd0, 8'h00, 1'b1, 1'b1, 8'h00};
    vecs[1] = '{8'h33, 8'h00, 8'h02, 4'd0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h02};
    vecs[2] = '{8'h7A, 8'h00, 8'h00, 4'd0, 2'd0, 8'h00, 1'b0, 1'b0, 8'hFF};
    vecs[3] = '{8'h11, 8'h01, 8'h00, 4'd1, 2'd1, 8'h03, 1'b1, 1'b0, 8'h03};
    vecs[4] = '{8'h22, 8'h01, 8'h00, 4'd3, 2'd2, 8'h09, 1'b1, 1'b1, 8'h00};
    vecs[5] = '{8'h44, 8'h02, 8'h00, 4'd0, 2'd0, 8'h00, 1'b0, 1'b0, 8'hFF};
    vecs[6] = '{8'h55, 8'h01, 8'h05, 4'd0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h05};

    reset_n = 1'b0;
    card_valid = 0; card_id = 0; key_press = 0; key_code = 0;
    key_confirm = 0; key_cancel = 0; system_ready = 1;
    system_status = 0; vote_accepted = 0; vote_rejected = 0; error_code = 0;
    last_code = 8'h00;
    step(); step();
    chk("rst_state", term_state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {voter_id_out, candidate_out, authenticate_voter, submit_vote,
                     ballot_done, fail, fail_code}, 0);
    reset_n = 1'b1;
    step();

    // card with system_ready low is ignored
    system_ready = 1'b0;
    card_valid   = 1'b1;
    card_id      = 8'h99;
    step();
    card_valid   = 1'b0;
    system_ready = 1'b1;
    chk("notready_card_state", term_state, 0);
    chk("notready_card_auth", authenticate_voter, 0);

    for (int v = 0; v < 7; v++) begin
      start_session(vecs[v].card);
      auth_phase(vecs[v].status, vecs[v].err);
      if (!vecs[v].auth_ok) begin
        chk("auth_fail", fail, 1);
        chk("auth_fail_code", fail_code, vecs[v].exp_code);
        chk("auth_fail_state", term_state, 0);
        chk("auth_fail_busy", busy, 0);
        last_code = vecs[v].exp_code;
      end else begin
        chk("state_select", term_state, 2);
        enter_choice(vecs[v].key);
        step();
        chk("submit_once", submit_vote, 0);
        vote_accepted = (vecs[v].resp != 2'd1);
        vote_rejected = (vecs[v].resp != 2'd0);
        error_code    = vecs[v].resp_err;
        step();
        vote_accepted = 1'b0;
        vote_rejected = 1'b0;
        error_code    = 8'h00;
        chk("done", ballot_done, vecs[v].exp_done);
        chk("fail", fail, !vecs[v].exp_done);
        if (!vecs[v].exp_done) last_code = vecs[v].exp_code;
        chk("resp_code", fail_code, last_code);
        chk("resp_state", term_state, 0);
        chk("resp_busy", busy, 0);
        chk("cand_held", candidate_out, vecs[v].key);
      end
      step();
      chk("pulse_clear", {ballot_done, fail}, 0);
    end

    // out-of-range key ignored, then silent controller times out
    start_session(8'h66);
    auth_phase(8'h01, 8'h00);
    key_press = 1'b1;
    key_code  = 4'd7;
    step();
    key_press = 1'b0;
    chk("oor_stays_select", term_state, 2);
    enter_choice(4'd1);
    for (int i = 0; i < RESP_TIMEOUT; i++) begin
      step();
      chk("no_early_timeout", fail, 0);
    end
    chk("timeout_still_submit", term_state, 4);
    step();
    chk("timeout_fail", fail, 1);
    chk("timeout_code", fail_code, 8'hFE);
    chk("timeout_state", term_state, 0);
    step();

    // cancel; card presented on the fail cycle must be ignored
    start_session(8'h77);
    auth_phase(8'h01, 8'h00);
`ifdef BALLOT_CONFIRM_EN
    key_press = 1'b1;
    key_code  = 4'd2;
    step();
    key_press = 1'b0;
    chk("cancel_pre_confirm", term_state, 3);
`endif
    key_cancel = 1'b1;
    step();
    key_cancel = 1'b0;
    chk("cancel_fail", fail, 1);
    chk("cancel_code", fail_code, 8'h10);
    card_valid = 1'b1;
    card_id    = 8'h88;
    step();
    card_valid = 1'b0;
    chk("card_on_fail_state", term_state, 0);
    chk("card_on_fail_auth", authenticate_voter, 0);
    step();

    // system_ready dropped together with a valid key in SELECT
    start_session(8'h12);
    auth_phase(8'h01, 8'h00);
    key_press    = 1'b1;
    key_code     = 4'd1;
    system_ready = 1'b0;
    step();
    key_press    = 1'b0;
    system_ready = 1'b1;
    chk("noready_fail", fail, 1);
    chk("noready_code", fail_code, 8'hFD);
    chk("noready_state", term_state, 0);
    step();

    // reset mid-SUBMIT: outputs clear immediately, no fail pulse
    start_session(8'h34);
    auth_phase(8'h01, 8'h00);
    enter_choice(4'd3);
    step();
    reset_n = 1'b0;
    #2;
    chk("rst_mid_state", term_state, 0);
    chk("rst_mid_outs", {voter_id_out, candidate_out, authenticate_voter, submit_vote,
                         busy, ballot_done, fail, fail_code}, 0);
    #1;
    reset_n = 1'b1;
    step();
    chk("rst_no_fail", fail, 0);
    chk("rst_idle", term_state, 0);
    chk("rst_busy_low", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
